// File: rtl/clz_norm.sv
// Multi-cycle CLZ/CLO counter and normalizer: a 5-stage binary search over the
// operand yields the leading-bit count and the word shifted left by that count.
module clz_norm (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [31:0] d,
  input  logic        ones,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count,
  output logic [31:0] norm
);

  // Handshake: start is accepted only in IDLE; busy is high from the accepting
  // edge until the result edge; done pulses for one cycle with count/norm valid.
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e      state_q;
  logic [31:0] x_q;
  logic [31:0] n_q;
  logic [5:0]  cnt_q;
  logic [2:0]  step_q;

  logic [4:0]  stage_sh;
  logic        stage_hit;
  logic [4:0]  shift_amt;

  // Stage s = 16 >> step; shift only if the top s bits of the search word are clear.
  always_comb begin
    stage_sh  = 5'd0;
    stage_hit = 1'b0;
    case (step_q)
      3'd0: begin stage_sh = 5'd16; stage_hit = (x_q[31:16] == 16'h0); end
      3'd1: begin stage_sh = 5'd8;  stage_hit = (x_q[31:24] == 8'h0);  end
      3'd2: begin stage_sh = 5'd4;  stage_hit = (x_q[31:28] == 4'h0);  end
      3'd3: begin stage_sh = 5'd2;  stage_hit = (x_q[31:30] == 2'h0);  end
      3'd4: begin stage_sh = 5'd1;  stage_hit = ~x_q[31];              end
      default: begin stage_sh = 5'd0; stage_hit = 1'b0; end
    endcase
  end

  assign shift_amt = stage_hit ? stage_sh : 5'd0;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      x_q     <= 32'h0;
      n_q     <= 32'h0;
      cnt_q   <= 6'd0;
      step_q  <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= 6'd0;
      norm    <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= ones ? ~d : d;
            n_q     <= d;
            cnt_q   <= 6'd0;
            step_q  <= 3'd0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q    <= x_q << shift_amt;
          n_q    <= n_q << shift_amt;
          cnt_q  <= cnt_q + {1'b0, shift_amt};
          step_q <= step_q + 3'd1;
          if (step_q == 3'd4) state_q <= FIN;
        end
        FIN: begin
          // A search word still clear at bit 31 means no terminating bit existed.
          if (!x_q[31]) begin
            count <= 6'd32;
            norm  <= 32'h0;
          end else begin
            count <= cnt_q;
            norm  <= n_q;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clz_norm.sv
// Directed bench for clz_norm: per-operation latency/handshake checks plus
// back-to-back, held-start and mid-operation reset scenarios.
module tb_clz_norm;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [31:0] d;
  logic        ones;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] norm;

  int n_checks = 0;
  int n_pass   = 0;
  logic [37:0] exp_q[$];

  clz_norm dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .d     (d),
    .ones  (ones),
    .busy  (busy),
    .done  (done),
    .count (count),
    .norm  (norm)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issues one operation, then checks busy/done timing and the result.
  task automatic run_op(input string tag, input logic [31:0] dv, input logic ov,
                        input logic [5:0] ec, input logic [31:0] en);
    int lat;
    bit bad;
    logic [5:0]  prev_cnt;
    logic [37:0] e;
    exp_q.push_back({ec, en});
    @(negedge clk);
    d = dv; ones = ov; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d = $urandom; ones = 1'($urandom_range(0, 1));
    prev_cnt = count;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    lat = 0; bad = 0;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (!done && (busy !== 1'b1 || count !== prev_cnt)) bad = 1;
    end
    check({tag, "_latency"}, lat, 6);
    check({tag, "_run_stable"}, 32'(bad), 32'd0);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check({tag, "_count"}, 32'(count), 32'(e[37:32]));
    check({tag, "_norm"}, norm, e[31:0]);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    clrn = 1'b0; start = 1'b0; d = 32'h0; ones = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_norm", norm, 32'd0);
    @(negedge clk); clrn = 1'b1;

    run_op("clz_10000", 32'h00010000, 1'b0, 6'd15, 32'h80000000);
    run_op("clz_zero",  32'h00000000, 1'b0, 6'd32, 32'h00000000);
    run_op("clz_msb",   32'h80000000, 1'b0, 6'd0,  32'h80000000);
    run_op("clz_one",   32'h00000001, 1'b0, 6'd31, 32'h80000000);
    run_op("clo_fff",   32'hFFF01234, 1'b1, 6'd12, 32'h01234000);
    run_op("clo_all",   32'hFFFFFFFF, 1'b1, 6'd32, 32'h00000000);
    run_op("clo_7ff",   32'h7FFFFFFF, 1'b1, 6'd0,  32'h7FFFFFFF);

    // start held high while busy, then still high in the done cycle
    @(negedge clk);
    d = 32'h00FF0000; ones = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    d = 32'h12345678;
    lat = 0;
    while (!done && lat < 12) begin @(posedge clk); #1; lat++; end
    check("hold_latency", lat, 6);
    check("hold_count", 32'(count), 32'd8);
    check("hold_norm", norm, 32'hFF000000);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("b2b_done_fall", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    while (!done && lat < 14) begin @(posedge clk); #1; lat++; end
    check("b2b_gap", lat, 7);
    check("b2b_count", 32'(count), 32'd3);
    check("b2b_norm", norm, 32'h91A2B3C0);
    @(posedge clk); #1;

    // reset at E3 aborts the operation
    @(negedge clk);
    d = 32'h00000001; ones = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    clrn = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_norm", norm, 32'd0);
    @(negedge clk); clrn = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (done) seen++; end
    check("abort_no_done", seen, 0);
    run_op("post_rst", 32'hFFF01234, 1'b1, 6'd12, 32'h01234000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clz_norm.md
# clz_norm

Iterative leading-zero/leading-one counter and normalizer for the uMIPS_32 datapath. It executes the MIPS32 CLZ/CLO instructions. It also serves as the inverse of the barrel shifter: given a data word, it recovers the left-shift amount that normalizes the word and produces the normalized word. The block sits beside the ALU as a multi-cycle unit with a start/busy/done handshake and stalls the pipeline while busy.

## Interface
Parameters: none. The width is fixed at 32 bits and the count at 6 bits.

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  synchronous, active-low reset; sampled on rising edge of clk
- start  input  1  request; accepted only on a rising edge where the unit is idle
- d  input  32  operand; captured on the accepting edge
- ones  input  1  1 = count leading ones (CLO); 0 = count leading zeros (CLZ); captured with d
- busy  output  1  high from the accepting edge until the result edge
- done  output  1  one-cycle pulse marking count/norm valid
- count  output  6  leading-bit count, 0..32
- norm  output  32  d << count (zero-filled); 0 when count = 32

## Operation
- Internal registers:
  - x: search word. Loaded as ones ? ~d : d.
  - n: copy of the original d.
  - cnt: 6-bit count.
  - step: 3-bit stage index.
- States and transitions:
  - IDLE: on start=1, load x, n, cnt=0, step=0; go to RUN.
  - RUN: one binary-search stage per cycle, with s = 16, 8, 4, 2, 1 for step = 0..4.
    - If x[31:32-s] == 0: x <= x << s, n <= n << s, cnt <= cnt + s.
    - After step 4, go to FIN.
  - FIN: zero fix-up.
    - If x[31] == 0 (the operand was all-zero for CLZ or all-one for CLO): cnt = 32, n = 0.
    - Register results to count/norm, pulse done, return to IDLE.
- Width rules:
  - cnt never exceeds 31 before FIN, so 6 bits suffice; there is no overflow.
  - Shifts on n and x are logical and zero-filled.
  - The CLO normalized word is the original d shifted, not the inverted word.
- Outputs count/norm hold their last result until the next FIN. They do not change during RUN.
- start while busy (RUN/FIN): ignored. There is no queueing and no error flag.
- d/ones changes after the accepting edge: no effect.
- Reset (clrn=0 at any edge, including mid-operation):
  - Aborts the operation; no done pulse.
  - Returns the state to IDLE.
  - Outputs: busy=0, done=0, count=0, norm=0.
  - Reset has priority over start.

## Timing
- Edge E0: start accepted. busy=1 after E0.
- Edges E1–E5: RUN stages.
- Edge E6: FIN. After E6, done=1 and count/norm are valid; busy=0.
- Latency: 6 clocks from the accepting edge to done. Throughput: one operation per 7 clocks.
- done is high for exactly one cycle, falling after E7.
- start high during the done cycle is accepted at E7 (back-to-back). The done pulse is unaffected.
- Fixed latency, independent of operand value.

## Test plan
- CLZ, d=0x00010000, ones=0:
  - count=15, norm=0x80000000.
  - done exactly 6 clocks after the start edge; busy high for those 6 cycles.
- CLZ of zero, d=0x00000000: count=32, norm=0x00000000.
- CLZ, d=0x80000000: count=0, norm=0x80000000.
- CLZ, d=0x00000001: count=31, norm=0x80000000.
- CLO, d=0xFFF01234, ones=1: count=12, norm=0x01234000.
- CLO, d=0xFFFFFFFF: count=32, norm=0.
- CLO, d=0x7FFFFFFF: count=0, norm unchanged.
- Handshake:
  - Assert start with d=0x00FF0000 and hold start high with a new d while busy: only one result (count=8, norm=0xFF000000).
  - Next start in the done cycle: second done 7 clocks after the first.
  - clrn=0 at E3: busy=0, done never pulses, count=0, norm=0; a fresh start afterwards completes normally.
